// File: rtl/program_loader.sv
// Loads BIP1 memory from the UART byte stream: little-endian 16-bit words, auto-incrementing address, stop on HLT or full memory.
// Optional PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte after HLT.
module program_loader #(
  parameter int NB_DATA    = 16,
  parameter int NB_OPERAND = 11,
  parameter int NB_BYTE    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_rx_done,
  input  logic [NB_BYTE-1:0]    i_rx_data,
  output logic                  o_wr_en,
  output logic [NB_OPERAND-1:0] o_wr_addr,
  output logic [NB_DATA-1:0]    o_wr_data,
  output logic                  o_busy,
  output logic                  o_load_done,
  output logic                  o_overflow,
  output logic                  o_chk_err
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOW, HIGH, WRITE, DONE, CHK} state_t;
  logic [NB_BYTE-1:0] chk_acc;
`else
  typedef enum logic [2:0] {IDLE, LOW, HIGH, WRITE, DONE} state_t;
  assign o_chk_err = 1'b0;
`endif

  state_t                state;
  logic [NB_OPERAND-1:0] addr;
  logic [NB_BYTE-1:0]    low_byte;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      low_byte    <= '0;
      o_wr_en     <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_busy      <= 1'b0;
      o_load_done <= 1'b0;
      o_overflow  <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      o_chk_err   <= 1'b0;
      chk_acc     <= '0;
`endif
    end else begin
      o_wr_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            state       <= LOW;
            addr        <= '0;
            o_busy      <= 1'b1;
            o_load_done <= 1'b0;
            o_overflow  <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            o_chk_err   <= 1'b0;
            chk_acc     <= '0;
`endif
          end
        end
        LOW: begin
          if (i_rx_done) begin
            low_byte <= i_rx_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            chk_acc  <= chk_acc ^ i_rx_data;
`endif
            state    <= HIGH;
          end
        end
        HIGH: begin
          // Word is captured straight into the output register so the strobe lands one cycle after the high byte.
          if (i_rx_done) begin
            o_wr_en   <= 1'b1;
            o_wr_addr <= addr;
            o_wr_data <= NB_DATA'({i_rx_data, low_byte});
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            chk_acc   <= chk_acc ^ i_rx_data;
`endif
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (o_wr_data == '0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state       <= CHK;
`else
            state       <= DONE;
            o_busy      <= 1'b0;
            o_load_done <= 1'b1;
`endif
          end else if (addr == {NB_OPERAND{1'b1}}) begin
            // Last location filled without HLT: stop rather than wrap onto address 0.
            state       <= DONE;
            o_busy      <= 1'b0;
            o_load_done <= 1'b1;
            o_overflow  <= 1'b1;
          end else begin
            addr  <= addr + 1'b1;
            state <= LOW;
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHK: begin
          if (i_rx_done) begin
            o_chk_err   <= (i_rx_data != chk_acc);
            state       <= DONE;
            o_busy      <= 1'b0;
            o_load_done <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
